// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package prefetch_pkg;

    localparam int PF_XLEN     = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [PF_XLEN-1:0] pc;
        logic [PF_XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } pf_state_t;

endpackage

// File: rtl/prefetch_if.sv
// Instruction-memory request/response bus plus the decode-side valid/ready handshake.
interface prefetch_if
    import prefetch_pkg::*;
#(
    parameter int XLEN = PF_XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    // master = prefetch unit, slave = memory + decode environment
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rvalid, imem_rdata, instr_ready
    );
endinterface

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous queue of fetch entries; flush overrides push and pop,
// push+pop while full is accepted. Head output reads 0 while empty.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] occupancy
);

    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    fetch_entry_t  mem_reg [DEPTH];
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign occupancy = count_reg;
    assign do_pop    = pop && !flush && !empty;
    assign do_push   = push && !flush && (!full || do_pop);
    assign dout      = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; the empty gate on dout hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/prefetch_unit.sv
// In-order instruction prefetch front end with redirect/drop handling.
// Optional fetch/drop statistics outputs are enabled by defining PREFETCH_STATS_EN.
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int              XLEN     = PF_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    prefetch_if.master      bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_dropped
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    pf_state_t       state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [XLEN-1:0] redirect_aligned;
    logic [CW-1:0]   inflight_reg, inflight_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0]   occupancy;
    logic [CW:0]     credit_used;
    logic            issue, fifo_push, fifo_pop, fifo_full, fifo_empty;
    fetch_entry_t    push_entry, head_entry;

    assign redirect_aligned = redirect_pc & ~(XLEN'(INSTR_BYTES) - XLEN'(1));

    // Queued words plus words still in flight may never exceed the queue size,
    // so every response is guaranteed a free slot.
    assign credit_used = {1'b0, occupancy} + {1'b0, inflight_reg};
    assign issue       = (state_reg == FETCH) && !redirect_valid && (credit_used < (CW+1)'(DEPTH));

    assign fifo_push = bus.imem_rvalid && (drop_cnt_reg == '0) && !redirect_valid;
    assign fifo_pop  = !fifo_empty && bus.instr_ready;

    assign push_entry.pc    = resp_pc_reg;
    assign push_entry.instr = bus.imem_rdata;

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_reg;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = head_entry.instr;
    assign bus.instr_pc    = head_entry.pc;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = FETCH;
            FETCH:   if (halt)  state_next = HALTED;
            HALTED:  if (!halt) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        inflight_next = inflight_reg + CW'(issue) - CW'(bus.imem_rvalid);
        drop_cnt_next = drop_cnt_reg;
        fetch_pc_next = fetch_pc_reg;
        resp_pc_next  = resp_pc_reg;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            drop_cnt_next = inflight_reg - CW'(bus.imem_rvalid);
            fetch_pc_next = redirect_aligned;
            resp_pc_next  = redirect_aligned;
        end else begin
            if (issue)     fetch_pc_next = fetch_pc_reg + XLEN'(INSTR_BYTES);
            if (fifo_push) resp_pc_next  = resp_pc_reg + XLEN'(INSTR_BYTES);
            if (bus.imem_rvalid && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            resp_pc_reg  <= resp_pc_next;
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .din       (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .dout      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(fifo_push && fifo_full));

`ifdef PREFETCH_STATS_EN
    logic [1:0] stat_inc;
    assign stat_inc = {bus.imem_rvalid && !fifo_push, fifo_push};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [31:0] cnt_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                cnt_reg <= '0;
            else if (stat_inc[gi] && (cnt_reg != '1))
                cnt_reg <= cnt_reg + 32'd1;
        end
    end

    assign stat_fetched = g_stat[0].cnt_reg;
    assign stat_dropped = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench: in-order memory model with programmable latency, epoch-tagged
// scoreboard of expected {pc, instr}, a reset-release vector table and directed corner cases.
`timescale 1ns/1ps
module tb_prefetch_unit;
    import prefetch_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_fetched, stat_dropped;
`endif

    prefetch_if #(.XLEN(XLEN)) bus();

    prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_dropped   (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic ready; logic req; logic [31:0] addr; logic valid; logic [31:0] pc; logic [31:0] instr; } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          req_count = 0;
    int          hs_count = 0;
    bit          ready_v = 1'b1, halt_v = 1'b0, rd_v = 1'b0, prev_rd = 1'b0, hs_seen = 1'b0;
    logic [31:0] rd_pc_v = '0, exp_req_pc = RESET_PC, hs_pc = '0;
    logic        s_req, s_valid, s_rvalid;
    logic [31:0] s_addr, s_instr, s_pc;
    mreq_t       mem_q[$];
    exp_t        sb[$];
    vec_t        vecs[7];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req),    32'h0);
        chk({tag, "_addr"},  bus.imem_addr,         RESET_PC);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
        chk({tag, "_instr"}, bus.instr,             32'h0);
        chk({tag, "_pc"},    bus.instr_pc,          32'h0);
    endtask

    // One clock cycle: drive inputs at the falling edge, sample #1 later, account
    // for what the coming rising edge will do, then advance past it.
    task automatic step();
        int    inflight_m, occ_m;
        bit    have_resp;
        mreq_t resp;
        exp_t  e;
        @(negedge clk);
        halt            = halt_v;
        bus.instr_ready = ready_v;
        redirect_valid  = rd_v;
        redirect_pc     = rd_pc_v;
        inflight_m      = mem_q.size();
        occ_m           = sb.size();
        have_resp       = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            resp            = mem_q.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(resp.addr);
            have_resp       = 1'b1;
        end
        if (rd_v && reset) begin
            epoch++;
            sb.delete();
            exp_req_pc = rd_pc_v & 32'hFFFF_FFFC;
        end
        #1;
        s_req    = bus.imem_req;
        s_addr   = bus.imem_addr;
        s_valid  = bus.instr_valid;
        s_instr  = bus.instr;
        s_pc     = bus.instr_pc;
        s_rvalid = bus.imem_rvalid;
        hs_seen  = 1'b0;
        if (reset) begin
            if (prev_rd) chk("valid_after_redirect", 32'(s_valid), 32'h0);
            if (s_valid && ready_v && !rd_v) begin
                hs_seen = 1'b1;
                hs_pc   = s_pc;
                hs_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got pc=%h with nothing expected", s_pc);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc", s_pc, e.pc);
                    chk("out_instr", s_instr, e.instr);
                    $display("cyc %0d out pc=%h instr=%h", cyc, s_pc, s_instr);
                end
            end
            if (have_resp && resp.epoch == epoch && !rd_v)
                sb.push_back('{resp.addr, mem_word(resp.addr)});
            if (rd_v) chk("no_req_on_redirect", 32'(s_req), 32'h0);
            if (s_req) begin
                req_count++;
                chk("req_addr", s_addr, exp_req_pc);
                chk("credit", 32'(inflight_m + occ_m < DEPTH), 32'h1);
                mem_q.push_back('{s_addr, cyc + lat, epoch});
                exp_req_pc = exp_req_pc + 32'd4;
            end
        end
        prev_rd = rd_v && reset;
        @(posedge clk);
        cyc++;
    endtask

    task automatic wait_hs(input string name, input logic [31:0] exp_pc, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = hs_seen;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no output within %0d cycles, expected pc %h", name, budget, exp_pc);
        end else begin
            chk(name, hs_pc, exp_pc);
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        rd_v    = 1'b1;
        rd_pc_v = pc;
        step();
        rd_v    = 1'b0;
    endtask

    initial begin
        int rc;
        //               ready req  addr          valid pc            instr
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0,         32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h5A5A_C3C3};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'h5A5A_C3C7};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h5A5A_C3CB};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C, 32'h5A5A_C3CF};

        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 check_reset("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // reset release with single-cycle memory, decode always ready
        for (int i = 0; i < 7; i++) begin
            ready_v = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_req", i),   32'(s_req),   32'(vecs[i].req));
            chk($sformatf("vec%0d_addr", i),  s_addr,       vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_pc", i),    s_pc,    vecs[i].pc);
                chk($sformatf("vec%0d_instr", i), s_instr, vecs[i].instr);
            end
        end
        repeat (8) step();

        // halt mid-stream: no further requests, queue drains, then sequential resume
        halt_v = 1'b1;
        step();
        rc = req_count;
        repeat (8) step();
        chk("halt_no_req", 32'(req_count - rc), 32'h0);
        chk("halt_drained_valid", 32'(s_valid), 32'h0);
        chk("halt_drained_sb", 32'(sb.size()), 32'h0);

        // decode stalled from an empty queue: exactly DEPTH requests then none
        ready_v = 1'b0;
        halt_v  = 1'b0;
        rc      = req_count;
        repeat (20) step();
        chk("stall_req_count", 32'(req_count - rc), 32'(DEPTH));
        chk("stall_req_low", 32'(s_req), 32'h0);
        chk("stall_queue_full", 32'(sb.size()), 32'(DEPTH));
        ready_v = 1'b1;
        rc      = req_count;
        repeat (8) step();
        chk("stall_resume", 32'(req_count > rc), 32'h1);

        // latency 3, redirect with words outstanding
        lat = 3;
        repeat (12) step();
        $display("cyc %0d redirect 0x103 with %0d outstanding", cyc, mem_q.size());
        redirect(32'h0000_0103);
        wait_hs("redirect_first_pc", 32'h0000_0100, 40);
        repeat (6) step();

        // redirect coinciding with a response and a handshake
        lat = 1;
        repeat (8) step();
        rd_v    = 1'b1;
        rd_pc_v = 32'h0000_0200;
        step();
        rd_v    = 1'b0;
        chk("corner_hit", 32'(s_valid && s_rvalid && ready_v), 32'h1);
        wait_hs("corner_first_pc", 32'h0000_0200, 20);

        // back-to-back redirects: the later one wins
        repeat (4) step();
        redirect(32'h0000_0300);
        redirect(32'h0000_0380);
        wait_hs("b2b_first_pc", 32'h0000_0380, 20);

        // redirect while halted
        halt_v = 1'b1;
        repeat (6) step();
        rc = req_count;
        redirect(32'h0000_0400);
        repeat (3) step();
        chk("halted_redirect_no_req", 32'(req_count - rc), 32'h0);
        halt_v = 1'b0;
        wait_hs("halted_redirect_pc", 32'h0000_0400, 20);

        // reset mid-operation with words in flight
        lat = 3;
        repeat (8) step();
        $display("cyc %0d reset with %0d outstanding", cyc, mem_q.size());
        #2 reset = 1'b0;
        #1 check_reset("midreset");
        repeat (5) step();
        check_reset("midreset_hold");
        mem_q.delete();
        sb.delete();
        prev_rd    = 1'b0;
        exp_req_pc = RESET_PC;
        #1 reset = 1'b1;
        wait_hs("restart_pc", RESET_PC, 20);
        repeat (6) step();

        // fetch address wrap
        lat = 1;
        redirect(32'hFFFF_FFFC);
        wait_hs("wrap_first_pc", 32'hFFFF_FFFC, 20);
        wait_hs("wrap_second_pc", 32'h0000_0000, 20);
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
